// File: rtl/mux8_rr_arbiter.sv
// -----------------------------------------------------------------------------
// mux8_rr_arbiter
//
// Round-robin arbiter and sequencer for an 8:1 one-bit datapath mux. One
// requester at a time owns the mux. While it holds the grant and keeps its
// request high, its data bit is captured into a registered output every cycle.
//
// Parameters
//   MAX_HOLD  maximum consecutive granted cycles per grant (1..255)
//
// Ports
//   clk      rising-edge clock
//   rst_n    asynchronous active-low reset
//   req      per-requester level request, bit k = requester k
//   data_in  per-requester data bit, bit k = requester k
//   gnt      registered one-hot grant, zero when idle
//   sel      registered mux select, index of the granted requester;
//            holds its last value while idle
//   busy     high while a grant is in progress
//   y        captured data bit, registered
//   y_valid  y holds a sample taken during a granted cycle
//
// Configuration
//   MUX8_ARB_HOLD_LIMIT_EN  when defined, a grant is force-released after
//                           MAX_HOLD granted cycles. When undefined, a grant
//                           lasts until the owner drops its request and
//                           MAX_HOLD only sizes the cycle counter.
// -----------------------------------------------------------------------------
module mux8_rr_arbiter #(
  parameter int MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  input  logic [7:0] data_in,
  output logic [7:0] gnt,
  output logic [2:0] sel,
  output logic       busy,
  output logic       y,
  output logic       y_valid
);

  // Wide enough to count 0..MAX_HOLD-1.
  localparam int CNT_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t           state, state_n;
  logic [2:0]       ptr, ptr_n;
  logic [2:0]       sel_n;
  logic [7:0]       gnt_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             y_n, y_valid_n;

  logic [15:0]      req2;
  logic [7:0]       rot;
  logic [2:0]       off;
  logic [2:0]       win;
  logic             granted;
  logic             hold_hit;
  logic             rel;

  // Rotate the requests so that bit 0 is the requester at ptr; the lowest set
  // bit of the rotated vector is then the first hit in search order.
  always_comb begin
    req2 = {req, req};
    rot  = req2[ptr +: 8];
    off  = '0;
    for (int i = 7; i >= 0; i--) begin
      if (rot[i]) off = 3'(i);
    end
    win = ptr + off;
  end

  // In GRANT, sel always names the owner, so it doubles as the owner index.
  assign granted = (state == GRANT) && req[sel];

`ifdef MUX8_ARB_HOLD_LIMIT_EN
  assign hold_hit = granted && (cnt == CNT_W'(MAX_HOLD - 1));
`else
  // No limit: cnt still counts granted cycles but simply wraps.
  assign hold_hit = 1'b0;
`endif

  assign rel = (state == GRANT) && (!req[sel] || hold_hit);

  // NOTE: every output of this block gets a default before the case so that
  // no path leaves a variable unassigned, which would infer a latch.
  always_comb begin
    state_n   = state;
    ptr_n     = ptr;
    sel_n     = sel;
    gnt_n     = gnt;
    cnt_n     = cnt;
    y_n       = y;
    y_valid_n = 1'b0;

    case (state)
      IDLE: begin
        if (|req) begin
          gnt_n   = 8'b1 << win;
          sel_n   = win;
          cnt_n   = '0;
          state_n = GRANT;
        end
      end
      GRANT: begin
        // A hold-limit release still takes the sample of that last cycle.
        if (granted) begin
          y_n       = data_in[sel];
          y_valid_n = 1'b1;
          cnt_n     = cnt + 1'b1;
        end
        // Release goes back through IDLE; no same-edge re-arbitration.
        if (rel) begin
          gnt_n   = '0;
          ptr_n   = sel + 3'd1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      ptr     <= '0;
      sel     <= '0;
      gnt     <= '0;
      cnt     <= '0;
      y       <= 1'b0;
      y_valid <= 1'b0;
    end else begin
      state   <= state_n;
      ptr     <= ptr_n;
      sel     <= sel_n;
      gnt     <= gnt_n;
      cnt     <= cnt_n;
      y       <= y_n;
      y_valid <= y_valid_n;
    end
  end

  // Decoded straight from the state register, so still free of input paths.
  assign busy = (state == GRANT);

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mux8_rr_arbiter
//
// Self-checking bench for mux8_rr_arbiter (MAX_HOLD = 3). A hand-written vector
// table covers single-requester capture, pointer advance and wrap; hand
// sequences cover async reset mid-grant, no preemption and the hold limit;
// a behavioural model feeds a scoreboard for rotation, all-requester and
// random traffic. Expectations follow MUX8_ARB_HOLD_LIMIT_EN if defined.
// -----------------------------------------------------------------------------
module tb_mux8_rr_arbiter;

  localparam int MAX_HOLD = 3;
`ifdef MUX8_ARB_HOLD_LIMIT_EN
  localparam bit HOLD_EN = 1'b1;
`else
  localparam bit HOLD_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] req;
  logic [7:0] data_in;
  logic [7:0] gnt;
  logic [2:0] sel;
  logic       busy;
  logic       y;
  logic       y_valid;

  mux8_rr_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .data_in (data_in),
    .gnt     (gnt),
    .sel     (sel),
    .busy    (busy),
    .y       (y),
    .y_valid (y_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] gnt;
    logic [2:0] sel;
    logic       busy;
    logic       y;
    logic       y_valid;
  } exp_t;

  typedef struct {
    logic [7:0] req;
    logic [7:0] data;
    logic [7:0] gnt;
    logic [2:0] sel;
    logic       y;
    logic       y_valid;
  } vec_t;

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];
  vec_t vec[15];

  // Behavioural reference state.
  bit         m_grant;
  int         m_k, m_cnt, m_ptr;
  logic [7:0] m_gnt;
  logic [2:0] m_sel;
  logic       m_y, m_yv;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare(input string tag, input exp_t e);
    check({tag, " gnt"},     32'(gnt),     32'(e.gnt));
    check({tag, " sel"},     32'(sel),     32'(e.sel));
    check({tag, " busy"},    32'(busy),    32'(e.busy));
    check({tag, " y"},       32'(y),       32'(e.y));
    check({tag, " y_valid"}, 32'(y_valid), 32'(e.y_valid));
  endtask

  // One clock of the reference: what the outputs become at the next edge.
  task automatic model_step(input logic [7:0] r, input logic [7:0] d, output exp_t e);
    if (!m_grant) begin
      m_yv = 1'b0;
      for (int i = 0; i < 8; i++) begin
        int j;
        j = (m_ptr + i) % 8;
        if (!m_grant && r[j]) begin
          m_grant = 1'b1;
          m_k     = j;
          m_cnt   = 0;
          m_gnt   = 8'(1 << j);
          m_sel   = 3'(j);
        end
      end
    end else begin
      bit done;
      done = 1'b0;
      if (r[m_k]) begin
        m_y  = d[m_k];
        m_yv = 1'b1;
        m_cnt++;
        if (HOLD_EN && m_cnt == MAX_HOLD) done = 1'b1;
      end else begin
        m_yv = 1'b0;
        done = 1'b1;
      end
      if (done) begin
        m_grant = 1'b0;
        m_gnt   = 8'h00;
        m_ptr   = (m_k + 1) % 8;
      end
    end
    e.gnt     = m_gnt;
    e.sel     = m_sel;
    e.busy    = m_grant;
    e.y       = m_y;
    e.y_valid = m_yv;
  endtask

  // Drive one cycle, push the model's prediction, compare after the edge.
  task automatic drive_cycle(input string tag, input logic [7:0] r, input logic [7:0] d);
    exp_t e;
    @(negedge clk);
    req     = r;
    data_in = d;
    model_step(r, d, e);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    compare(tag, exp_q.pop_front());
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int   hold_cnt;
    exp_t e;

    // Expected outputs after the edge that samples {req, data}.
    vec[0]  = '{8'h04, 8'h00, 8'h04, 3'd2, 1'b0, 1'b0}; // winner 2
    vec[1]  = '{8'h04, 8'h04, 8'h04, 3'd2, 1'b1, 1'b1}; // sample 1
    vec[2]  = '{8'h04, 8'h00, 8'h04, 3'd2, 1'b0, 1'b1}; // sample 0
    vec[3]  = '{8'h00, 8'h04, 8'h00, 3'd2, 1'b0, 1'b0}; // drop, ptr=3
    vec[4]  = '{8'h0C, 8'h08, 8'h08, 3'd3, 1'b0, 1'b0}; // 3 beats 2
    vec[5]  = '{8'h0C, 8'h08, 8'h08, 3'd3, 1'b1, 1'b1};
    vec[6]  = '{8'h04, 8'hFF, 8'h00, 3'd3, 1'b1, 1'b0}; // drop, no sample
    vec[7]  = '{8'h04, 8'h00, 8'h04, 3'd2, 1'b1, 1'b0}; // ptr=4 -> 2
    vec[8]  = '{8'h84, 8'h00, 8'h04, 3'd2, 1'b0, 1'b1}; // 7 ignored
    vec[9]  = '{8'h80, 8'h80, 8'h00, 3'd2, 1'b0, 1'b0}; // drop, ptr=3
    vec[10] = '{8'h80, 8'h80, 8'h80, 3'd7, 1'b0, 1'b0}; // winner 7
    vec[11] = '{8'h81, 8'h80, 8'h80, 3'd7, 1'b1, 1'b1};
    vec[12] = '{8'h01, 8'h00, 8'h00, 3'd7, 1'b1, 1'b0}; // ptr wraps to 0
    vec[13] = '{8'h81, 8'h00, 8'h01, 3'd0, 1'b1, 1'b0}; // 0 beats 7
    vec[14] = '{8'h00, 8'h00, 8'h00, 3'd0, 1'b1, 1'b0};

    rst_n   = 1'b0;
    req     = 8'h00;
    data_in = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    compare("reset", '{8'h00, 3'd0, 1'b0, 1'b0, 1'b0});
    @(negedge clk);
    rst_n = 1'b1;

    // Vector table.
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      req     = vec[i].req;
      data_in = vec[i].data;
      exp_q.push_back('{vec[i].gnt, vec[i].sel, (vec[i].gnt != 8'h00),
                        vec[i].y, vec[i].y_valid});
      @(posedge clk);
      #1;
      compare($sformatf("vec%0d", i), exp_q.pop_front());
    end

    // Asynchronous reset in the middle of a grant to requester 6.
    @(negedge clk);
    req = 8'h40;
    @(posedge clk);
    #1;
    check("rst_pre gnt", 32'(gnt), 32'h40);
    check("rst_pre sel", 32'(sel), 32'd6);
    #2;
    rst_n = 1'b0;
    #1;
    compare("rst_async", '{8'h00, 3'd0, 1'b0, 1'b0, 1'b0});
    @(negedge clk);
    req   = 8'h41;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    compare("rst_regrant", '{8'h01, 3'd0, 1'b1, 1'b0, 1'b0});

    // Align the reference with the known post-reset grant to requester 0.
    m_grant = 1'b1; m_k = 0; m_cnt = 0; m_ptr = 0;
    m_gnt = 8'h01; m_sel = 3'd0; m_y = 1'b0; m_yv = 1'b0;

    // Hold limit: requester 4 asks for 10 cycles.
    drive_cycle("hold_pre", 8'h00, 8'h00);
    drive_cycle("hold_pre", 8'h00, 8'h00);
    hold_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      drive_cycle("hold", 8'h10, 8'($urandom));
      if (gnt == 8'h10) hold_cnt++;
    end
    check("hold granted cycles", 32'(hold_cnt), HOLD_EN ? 32'd8 : 32'd10);

    // No preemption: 5 holds while 1 arrives, then 1 after one idle cycle.
    drive_cycle("npre", 8'h00, 8'h00);
    drive_cycle("npre", 8'h00, 8'h00);
    drive_cycle("npre", 8'h20, 8'h20);
    drive_cycle("npre", 8'h22, 8'h20);
    check("npre held gnt", 32'(gnt), 32'h20);
    drive_cycle("npre", 8'h02, 8'h02);
    check("npre release gnt", 32'(gnt), 32'h00);
    drive_cycle("npre", 8'h02, 8'h02);
    check("npre next gnt", 32'(gnt), 32'h02);
    drive_cycle("npre", 8'h00, 8'h00);

    // Rotation between 0 and 7, then all requesters.
    for (int i = 0; i < 12; i++) drive_cycle("rot81", 8'h81, 8'($urandom));
    drive_cycle("gap", 8'h00, 8'h00);
    drive_cycle("gap", 8'h00, 8'h00);
    for (int i = 0; i < 30; i++) drive_cycle("allreq", 8'hFF, 8'($urandom));

    // Random traffic, requests biased towards staying high.
    for (int i = 0; i < 300; i++) begin
      drive_cycle("rand", 8'($urandom) | 8'($urandom), 8'($urandom));
      check("rand onehot", 32'($countones(gnt) <= 1), 32'd1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
